apb_req_bridge: RTL

Single-outstanding APB master that turns a simple valid/ready command interface into APB3/APB4 transfers on the `tim_*` bus driving the timer subsystem. It sits directly upstream of the timer top: CPU-side or test-side logic issues register reads and writes here; this block sequences SETUP/ACCESS phases, waits on `tim_pready`, and returns read data plus error status on a response handshake.

---
 rtl/apb_req_bridge_if.sv | 46 ++++
 rtl/apb_req_bridge.sv | 102 ++++++++++
 2 files changed

// File: rtl/apb_req_bridge_if.sv
// rtl/apb_req_bridge_if.sv - command/response and APB bus bundle for apb_req_bridge
interface apb_req_bridge_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_wdata;
    logic [DATA_W/8-1:0]   cmd_strb;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  busy;
    logic                  tim_psel;
    logic                  tim_penable;
    logic                  tim_pwrite;
    logic [ADDR_W-1:0]     tim_paddr;
    logic [DATA_W-1:0]     tim_pwdata;
    logic [DATA_W/8-1:0]   tim_pstrb;
    logic                  tim_pready;
    logic                  tim_pslverr;
    logic [DATA_W-1:0]     tim_prdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output busy,
        output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
        input  tim_pready, tim_pslverr, tim_prdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  busy,
        input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
        output tim_pready, tim_pslverr, tim_prdata
    );
endinterface

// File: rtl/apb_req_bridge.sv
// rtl/apb_req_bridge.sv - single-outstanding APB master bridge; APB_BRIDGE_TIMEOUT_EN adds a wait-state abort
module apb_req_bridge #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    apb_req_bridge_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   timeout_hit;
    logic   access_end;

`ifdef APB_BRIDGE_TIMEOUT_EN
    logic [7:0] wait_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wait_cnt <= 8'd0;
        end else if (state == SETUP) begin
            wait_cnt <= 8'd0;
        end else if (state == ACCESS && !bus.tim_pready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Fires on the edge that would make the count reach the limit; pready on that cycle still wins.
    assign timeout_hit = (state == ACCESS) && !bus.tim_pready &&
                         (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign access_end = (state == ACCESS) && (bus.tim_pready || timeout_hit);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.cmd_valid) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (access_end) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status and bus controls are decoded from the next state so every output is a flop.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bus.cmd_ready   <= 1'b1;
            bus.busy        <= 1'b0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.tim_psel    <= 1'b0;
            bus.tim_penable <= 1'b0;
            bus.tim_pwrite  <= 1'b0;
            bus.tim_paddr   <= '0;
            bus.tim_pwdata  <= '0;
            bus.tim_pstrb   <= '0;
        end else begin
            bus.cmd_ready   <= (state_nxt == IDLE);
            bus.busy        <= (state_nxt != IDLE);
            bus.rsp_valid   <= (state_nxt == RESP);
            bus.tim_psel    <= (state_nxt == SETUP) || (state_nxt == ACCESS);
            bus.tim_penable <= (state_nxt == ACCESS);

            if (state == IDLE && bus.cmd_valid) begin
                bus.tim_pwrite <= bus.cmd_write;
                bus.tim_paddr  <= bus.cmd_addr;
                if (bus.cmd_write) begin
                    bus.tim_pwdata <= bus.cmd_wdata;
                    bus.tim_pstrb  <= bus.cmd_strb;
                end else begin
                    bus.tim_pstrb  <= '0;
                end
            end

            if (access_end) begin
                bus.rsp_err   <= bus.tim_pready ? bus.tim_pslverr : 1'b1;
                bus.rsp_rdata <= (bus.tim_pready && !bus.tim_pwrite) ? bus.tim_prdata : '0;
            end
        end
    end
endmodule
